// File: rtl/irqctl_pkg.sv
// Shared constants for the irqctl interrupt controller: register offsets,
// source count and the CTRL enable bit position.
package irqctl_pkg;
  localparam int N_SRC = 8;

  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_MODE = 3'd2;
  localparam logic [2:0] REG_VEC  = 3'd3;
  localparam logic [2:0] REG_ACK  = 3'd4;
  localparam logic [2:0] REG_EOI  = 3'd5;
  localparam logic [2:0] REG_ISR  = 3'd6;
  localparam logic [2:0] REG_CTRL = 3'd7;

  localparam int CTRL_EN = 0;
endpackage

// File: rtl/irqctl_prio.sv
// 8-bit priority encoder: lowest set bit wins, valid when any bit is set.
module irqctl_prio (
  input  logic [7:0] vec,
  output logic       valid,
  output logic [2:0] idx
);
  always_comb begin
    valid = |vec;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (vec[i]) idx = 3'(i);
  end
endmodule

// File: rtl/irqctl.sv
// 8-source latched/masked/prioritised interrupt controller with in-service stack.
// Optional IRQCTL_SYNC_EN adds a 2-flop synchronizer on every irq_in bit.
module irqctl #(
  parameter int N_SRC = irqctl_pkg::N_SRC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       AD,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  input  logic             rw,
  input  logic             cs,
  input  logic [N_SRC-1:0] irq_in,
  output logic             irq
);
  import irqctl_pkg::*;

  logic [N_SRC-1:0] src, hist, pend, pend_nxt, mask, mode, isr;
  logic [N_SRC-1:0] edge_det, clr, ack_bit, pm;
  logic             ctrl_en, wr, req;
  logic             p_vld, i_vld;
  logic [2:0]       p_idx, i_idx;

`ifdef IRQCTL_SYNC_EN
  logic [N_SRC-1:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end
  assign src = sync2;
`else
  assign src = irq_in;
`endif

  assign wr       = cs && !rw;
  assign edge_det = src & ~hist;
  assign ack_bit  = N_SRC'(1) << DI[2:0];
  assign clr      = ((wr && AD == REG_PEND) ? DI      : '0)
                  | ((wr && AD == REG_ACK)  ? ack_bit : '0);
  // Edge bits: a new edge beats a same-cycle clear. Level bits just track the input.
  assign pend_nxt = (mode & (edge_det | (pend & ~clr))) | (~mode & src);
  assign pm       = pend & mask;

  irqctl_prio u_pend_prio (.vec(pm),  .valid(p_vld), .idx(p_idx));
  irqctl_prio u_isr_prio  (.vec(isr), .valid(i_vld), .idx(i_idx));

  assign req = ctrl_en && p_vld && (!i_vld || p_idx < i_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= '0;
      hist    <= '0;
      mask    <= '0;
      mode    <= '0;
      isr     <= '0;
      ctrl_en <= 1'b0;
      irq     <= 1'b0;
    end else begin
      pend <= pend_nxt;
      hist <= src;
      irq  <= req;
      if (wr) begin
        case (AD)
          REG_MASK: mask    <= DI;
          REG_MODE: mode    <= DI;
          REG_CTRL: ctrl_en <= DI[CTRL_EN];
          REG_ACK:  isr     <= isr | ack_bit;
          // Clear lowest set bit; a no-op when isr is zero.
          REG_EOI:  isr     <= isr & (isr - N_SRC'(1));
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    DO = 8'h00;
    case (AD)
      REG_PEND: DO = pend;
      REG_MASK: DO = mask;
      REG_MODE: DO = mode;
      REG_VEC:  DO = p_vld ? {1'b1, 4'b0000, p_idx} : 8'h00;
      REG_ISR:  DO = isr;
      REG_CTRL: DO = {7'b0000000, ctrl_en};
      default:  DO = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_irqctl.sv
// Directed bench for irqctl: a bit-level behavioural model checked every cycle,
// plus hand-computed literal expectations along the test plan.
module tb_irqctl;
  logic       clk, rst, rw, cs, irq;
  logic [2:0] AD;
  logic [7:0] DI, DO, irq_in;
  int n_cmp = 0, n_bad = 0;

`ifdef IRQCTL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  irqctl dut (.clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
              .irq_in(irq_in), .irq(irq));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  logic [7:0] m_pend, m_mask, m_mode, m_isr, m_prev, m_s1, m_s2;
  logic       m_ctrl, m_irq;

  function automatic int lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic logic [7:0] exp_do(logic [2:0] a);
    logic [7:0] pm;
    logic [2:0] ix;
    pm = m_pend & m_mask;
    ix = 3'(lowest(pm));
    case (a)
      3'd0: return m_pend;
      3'd1: return m_mask;
      3'd2: return m_mode;
      3'd3: return (pm == 0) ? 8'h00 : {1'b1, 4'b0000, ix};
      3'd6: return m_isr;
      3'd7: return {7'b0, m_ctrl};
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : upd
    logic [7:0] s, np;
    logic w;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_mode = 0; m_isr = 0; m_prev = 0;
      m_s1 = 0; m_s2 = 0; m_ctrl = 0; m_irq = 0;
    end else begin
`ifdef IRQCTL_SYNC_EN
      s = m_s2; m_s2 = m_s1; m_s1 = irq_in;
`else
      s = irq_in;
`endif
      w = cs && !rw;
      m_irq = m_ctrl && ((m_pend & m_mask) != 0) && (lowest(m_pend & m_mask) < lowest(m_isr));
      for (int n = 0; n < 8; n++) begin
        if (!m_mode[n])                 np[n] = s[n];
        else if (s[n] && !m_prev[n])    np[n] = 1'b1;
        else if (w && ((AD == 3'd0 && DI[n]) || (AD == 3'd4 && int'(DI[2:0]) == n)))
                                        np[n] = 1'b0;
        else                            np[n] = m_pend[n];
      end
      if (w) begin
        case (AD)
          3'd1: m_mask = DI;
          3'd2: m_mode = DI;
          3'd7: m_ctrl = DI[0];
          3'd4: m_isr[DI[2:0]] = 1'b1;
          3'd5: if (m_isr != 0) m_isr[lowest(m_isr)] = 1'b0;
          default: ;
        endcase
      end
      m_pend = np;
      m_prev = s;
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_irq", {7'b0, irq}, {7'b0, m_irq});
    chk("model_do", DO, exp_do(AD));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    AD = a; DI = d; cs = 1; rw = 0;
    tick();
    cs = 0; rw = 1;
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [7:0] exp);
    AD = a; cs = 1; rw = 1;
    @(negedge clk);
    chk(nm, DO, exp);
    tick();
    cs = 0;
  endtask

  task automatic chk_irq(input string nm, input logic exp);
    chk(nm, {7'b0, irq}, {7'b0, exp});
  endtask

  initial begin
    rst = 1; cs = 0; rw = 1; AD = 0; DI = 0; irq_in = 0;
    repeat (3) tick();
    rst = 0;
    chk_irq("reset_irq", 1'b0);
    for (int a = 0; a < 8; a++) rd("reset_reg", 3'(a), 8'h00);

    // edge source 0
    wr(3'd2, 8'h01); wr(3'd1, 8'h01); wr(3'd7, 8'h01);
    irq_in = 8'h01;
    repeat (LAT + 1) tick();
    chk_irq("edge_irq_lat", 1'b0);
    tick();
    chk_irq("edge_irq", 1'b1);
    irq_in = 8'h00;
    rd("edge_vec", 3'd3, 8'h80);
    rd("edge_pend", 3'd0, 8'h01);
    wr(3'd4, 8'h00);
    tick();
    chk_irq("ack_irq", 1'b0);
    rd("ack_isr", 3'd6, 8'h01);
    rd("ack_pend", 3'd0, 8'h00);
    wr(3'd5, 8'h00);
    rd("eoi_isr", 3'd6, 8'h00);

    // priority / nesting with level sources
    wr(3'd2, 8'h00); wr(3'd1, 8'h28);
    irq_in = 8'h28;
    repeat (LAT + 2) tick();
    chk_irq("prio_irq", 1'b1);
    rd("prio_vec", 3'd3, 8'h83);
    wr(3'd4, 8'h03);
    tick();
    chk_irq("prio_blocked", 1'b0);
    irq_in = 8'h2A;
    wr(3'd1, 8'h2A);
    repeat (LAT + 2) tick();
    chk_irq("nest_irq", 1'b1);
    rd("nest_vec", 3'd3, 8'h81);
    wr(3'd4, 8'h01); wr(3'd5, 8'h00);
    rd("nest_isr", 3'd6, 8'h08);
    irq_in = 8'h00;
    wr(3'd5, 8'h00);
    repeat (LAT + 2) tick();
    chk_irq("nest_idle", 1'b0);
    rd("nest_isr0", 3'd6, 8'h00);

    // set-vs-clear race on source 2
    wr(3'd2, 8'h04); wr(3'd1, 8'h04);
    irq_in = 8'h04;
    repeat (LAT) tick();
    wr(3'd0, 8'h04);
    rd("race_pend", 3'd0, 8'h04);
    wr(3'd0, 8'h04);
    rd("w1c_pend", 3'd0, 8'h00);

    // mask / enable gating
    irq_in = 8'h00;
    repeat (LAT + 2) tick();
    irq_in = 8'h04;
    repeat (LAT + 2) tick();
    chk_irq("gate_on", 1'b1);
    wr(3'd1, 8'h00);
    tick();
    chk_irq("mask_off", 1'b0);
    rd("mask_pend", 3'd0, 8'h04);
    wr(3'd1, 8'h04);
    chk_irq("mask_lat", 1'b0);
    tick();
    chk_irq("mask_on", 1'b1);
    wr(3'd7, 8'h00);
    tick();
    chk_irq("ctrl_off", 1'b0);
    rd("ctrl_pend", 3'd0, 8'h04);
    rd("ctrl_rd", 3'd7, 8'h00);
    wr(3'd7, 8'hFF);
    tick();
    chk_irq("ctrl_on", 1'b1);
    rd("ctrl_rd1", 3'd7, 8'h01);

    // level->edge switch with input high creates no edge
    irq_in = 8'h84;
    repeat (LAT + 1) tick();
    wr(3'd2, 8'h84);
    tick();
    rd("mode_pend", 3'd0, 8'h84);
    wr(3'd0, 8'h80);
    rd("mode_noedge", 3'd0, 8'h04);

    // asynchronous reset mid-operation
    AD = 3'd0;
    @(posedge clk); #3;
    irq_in = 8'h00;
    rst = 1;
    #1;
    chk_irq("arst_irq", 1'b0);
    chk("arst_pend", DO, 8'h00);
    tick();
    rst = 0;
    repeat (2) tick();
    rd("post_rst_mask", 3'd1, 8'h00);
    rd("post_rst_isr", 3'd6, 8'h00);
    chk_irq("post_rst_irq", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
